// File: rtl/mesh_drain_if.sv
// Row-stream interface from mesh_drain to the writeback path: one mesh row per beat,
// valid/ready handshake.
interface mesh_drain_if #(
    parameter int RES_BIT = 8,
    parameter int MESH_X  = 4,
    parameter int ROW_W   = 2
);
    logic                      out_valid;
    logic                      out_ready;
    logic [RES_BIT*MESH_X-1:0] out_data;
    logic [ROW_W-1:0]          out_row;
    logic                      out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mesh_drain.sv
// Snapshots the mesh accumulators, clears the mesh, and streams requantized rows out.
// Optional build macro MESH_DRAIN_RELU_EN clamps negative results to zero.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | snapshot held, mesh_clr pulsing, row 0 being requantized
// SEND  | presenting rows to the consumer
module mesh_drain #(
    parameter int OUT_BIT   = 20,
    parameter int MESH_X    = 4,
    parameter int MESH_Y    = 4,
    parameter int RES_BIT   = 8,
    parameter int SHIFT_BIT = 5,
    parameter int ROW_W     = (MESH_Y > 1) ? $clog2(MESH_Y) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [SHIFT_BIT-1:0]             shift,
    input  logic [OUT_BIT*MESH_X*MESH_Y-1:0] acc_in,
    output logic                             mesh_clr,
    output logic                             busy,
    output logic                             done,
    mesh_drain_if.master                     out_if
);
    localparam int EW = OUT_BIT + 1;
    localparam logic signed [EW-1:0] SAT_MAX = EW'((2 ** (RES_BIT - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t                           state;
    logic [OUT_BIT*MESH_X*MESH_Y-1:0] snap_q;
    logic [SHIFT_BIT-1:0]             shift_q;
    logic                             mesh_clr_q;
    logic                             busy_q;
    logic                             done_q;
    logic                             valid_q;
    logic [RES_BIT*MESH_X-1:0]        data_q;
    logic [ROW_W-1:0]                 row_q;
    logic                             last_q;
    logic [ROW_W-1:0]                 row_sel;
    logic [RES_BIT*MESH_X-1:0]        row_data;

    // Extra sign bit keeps the rounding add from overflowing; shifts past the
    // accumulator width degenerate to a pure sign fill.
    function automatic logic [RES_BIT-1:0] quant(input logic signed [OUT_BIT-1:0] a,
                                                 input logic [SHIFT_BIT-1:0] s);
        logic signed [EW-1:0] ext;
        logic signed [EW-1:0] rnd;
        logic signed [EW-1:0] t;
        logic [RES_BIT-1:0]   r;
        ext = {a[OUT_BIT-1], a};
        rnd = '0;
        if (s != '0 && int'(s) <= OUT_BIT)
            rnd = EW'(1) << (s - 1'b1);
        t = (ext + rnd) >>> s;
        if (t > SAT_MAX)
            r = SAT_MAX[RES_BIT-1:0];
        else if (t < SAT_MIN)
            r = SAT_MIN[RES_BIT-1:0];
        else
            r = t[RES_BIT-1:0];
`ifdef MESH_DRAIN_RELU_EN
        if (r[RES_BIT-1])
            r = '0;
`endif
        return r;
    endfunction

    always_comb begin
        row_sel = (state == SEND) ? row_q + ROW_W'(1) : '0;
    end

    always_comb begin
        row_data = '0;
        for (int k = 0; k < MESH_X; k++) begin
            row_data[k*RES_BIT +: RES_BIT] =
                quant(snap_q[(int'(row_sel) * MESH_X + k) * OUT_BIT +: OUT_BIT], shift_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            snap_q     <= '0;
            shift_q    <= '0;
            mesh_clr_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            row_q      <= '0;
            last_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            mesh_clr_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap_q     <= acc_in;
                        shift_q    <= shift;
                        busy_q     <= 1'b1;
                        mesh_clr_q <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    data_q  <= row_data;
                    row_q   <= '0;
                    last_q  <= (MESH_Y == 1);
                    valid_q <= 1'b1;
                    state   <= SEND;
                end
                SEND: begin
                    if (valid_q && out_if.out_ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            data_q <= row_data;
                            row_q  <= row_sel;
                            last_q <= (int'(row_sel) == MESH_Y - 1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mesh_clr         = mesh_clr_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_row   = row_q;
    assign out_if.out_last  = last_q;
endmodule

// File: tb/tb_mesh_drain.sv
// Directed bench for mesh_drain: fixed accumulator patterns with hand-computed rows,
// backpressure, ignored re-start, back-to-back start and mid-drain reset.
module tb_mesh_drain;
   localparam int OUT_BIT = 20;
   localparam int MESH_X  = 4;
   localparam int MESH_Y  = 4;
   localparam int NACC    = MESH_X * MESH_Y;
`ifdef MESH_DRAIN_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic                       clk = 1'b0;
   logic                       rst = 1'b1;
   logic                       start = 1'b0;
   logic [4:0]                 shift = '0;
   logic [OUT_BIT*NACC-1:0]    acc_in = '0;
   logic                       mesh_clr;
   logic                       busy;
   logic                       done;
   int                         n_checks = 0;
   int                         n_errors = 0;

   mesh_drain_if #(.RES_BIT(8), .MESH_X(MESH_X), .ROW_W(2)) dut_if ();

   mesh_drain dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .shift    (shift),
      .acc_in   (acc_in),
      .mesh_clr (mesh_clr),
      .busy     (busy),
      .done     (done),
      .out_if   (dut_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int v);
      for (int j = 0; j < NACC; j++) acc_in[j*OUT_BIT +: OUT_BIT] = OUT_BIT'(v);
   endtask

   task automatic set_acc(input int j, input int v);
      acc_in[j*OUT_BIT +: OUT_BIT] = OUT_BIT'(v);
   endtask

   // exp holds row r at [r*32 +: 32]; rdy bit c drives out_ready on SEND cycle c.
   // restart_cyc >= 0 pulses start with different data on that SEND cycle.
   task automatic drain(input string tag, input logic [127:0] exp, input logic [31:0] rdy,
                        input int restart_cyc);
      int  er;
      bit  fin;
      er  = 0;
      fin = 1'b0;
      dut_if.out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      acc_in = ~acc_in;
      check({tag, "_clr"}, 32'(mesh_clr), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_load_valid"}, 32'(dut_if.out_valid), 32'd0);
      tick();
      check({tag, "_clr_off"}, 32'(mesh_clr), 32'd0);
      for (int c = 0; c < 40 && !fin; c++) begin
         dut_if.out_ready = (c < 32) ? rdy[c] : 1'b1;
         if (c == restart_cyc) begin
            start = 1'b1;
            fill(-1000);
            shift = 5'd0;
         end else begin
            start = 1'b0;
         end
         check({tag, "_valid"}, 32'(dut_if.out_valid), 32'd1);
         check({tag, "_row"}, 32'(dut_if.out_row), 32'(er));
         check({tag, "_data"}, dut_if.out_data, exp[er*32 +: 32]);
         check({tag, "_last"}, 32'(dut_if.out_last), 32'(er == MESH_Y - 1));
         check({tag, "_early_done"}, 32'(done), 32'd0);
         tick();
         if (dut_if.out_ready) begin
            if (er == MESH_Y - 1) fin = 1'b1;
            else er++;
         end
      end
      start = 1'b0;
      check({tag, "_finished"}, 32'(fin), 32'd1);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_valid"}, 32'(dut_if.out_valid), 32'd0);
   endtask

   task automatic done_clears(input string tag);
      tick();
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] exp_a, exp_b, exp_c, exp_d, exp_f;
      exp_a = {4{32'h7D7D7D7D}};
      exp_b = RELU ? 128'd0 : {4{32'h83838383}};
      exp_c = {96'd0, RELU ? 32'h7F007F32 : 32'h7F807F32};
      exp_d = {32'h7F7F7F7F, 32'h7F7F7F7F, RELU ? 32'h00020001 : 32'hFE02FF01, 32'h7F7F7F7F};
      exp_f = {96'd0, RELU ? 32'h00000000 : 32'h000000FF};

      dut_if.out_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_clr", 32'(mesh_clr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(dut_if.out_valid), 32'd0);
      check("rst_data", dut_if.out_data, 32'd0);
      check("rst_row", 32'(dut_if.out_row), 32'd0);
      check("rst_last", 32'(dut_if.out_last), 32'd0);

      fill(1000);
      shift = 5'd3;
      drain("pos", exp_a, 32'hFFFFFFFF, -1);
      done_clears("pos");

      fill(-1000);
      shift = 5'd3;
      drain("neg", exp_b, 32'hFFFFFFFF, -1);
      done_clears("neg");

      fill(0);
      set_acc(0, 50);
      set_acc(1, 200);
      set_acc(2, -300);
      set_acc(3, 127);
      shift = 5'd0;
      drain("sat", exp_c, 32'hFFFFFFFF, -1);
      done_clears("sat");

      fill(5000);
      set_acc(4, 5);
      set_acc(5, -6);
      set_acc(6, 6);
      set_acc(7, -7);
      shift = 5'd2;
      drain("bp", exp_d, 32'h00000069, -1);
      done_clears("bp");

      fill(1000);
      shift = 5'd3;
      drain("restart", exp_a, 32'hFFFFFFFF, 1);
      fill(0);
      set_acc(0, -1000);
      set_acc(1, 1000);
      shift = 5'd25;
      drain("b2b_wide", exp_f, 32'hFFFFFFFF, -1);
      done_clears("b2b_wide");

      fill(1000);
      shift = 5'd3;
      dut_if.out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check("mid_row", 32'(dut_if.out_row), 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_valid", 32'(dut_if.out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      tick();
      check("mid_rst_done2", 32'(done), 32'd0);
      fill(-1000);
      shift = 5'd3;
      drain("after_rst", exp_b, 32'hFFFFFFFF, -1);
      done_clears("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
